// File: rtl/conv_engine.sv
// conv_engine: NK parallel 3x3 signed fixed-point convolution kernels applied
// to one window per cycle. Three-stage elastic pipeline:
//   S1 products, S2 partial sums, S3 rounded/saturated/ReLU result.
module conv_engine #(
    parameter int                 DW     = 20,
    parameter int                 FRAC   = 16,
    parameter int                 NK     = 2,
    parameter logic [NK*9*DW-1:0] W_INIT = '0,
    parameter logic [NK*DW-1:0]   B_INIT = '0,
    localparam int                KW     = (NK > 1) ? $clog2(NK) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_valid,
    output logic              i_ready,
    input  logic [9*DW-1:0]   i_data,
    input  logic              relu_en,
    input  logic              w_we,
    input  logic [KW-1:0]     w_kidx,
    input  logic [3:0]        w_tap,
    input  logic [DW-1:0]     w_data,
    output logic              o_valid,
    input  logic              o_ready,
    output logic [NK*DW-1:0]  o_data
);

    // Handshake: a transfer happens on a rising edge where valid && ready.
    // Once o_valid is high, o_valid and o_data hold until o_ready is seen.
    // i_ready never depends on i_valid; o_valid never depends on o_ready.

    localparam int PW = 2 * DW;
    localparam int AW = 2 * DW + 4;
    localparam logic signed [AW-1:0] SAT_MAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};
    localparam logic [DW-1:0]        OUT_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0]        OUT_MIN = {1'b1, {(DW-1){1'b0}}};

    // Coefficient storage
    logic signed [DW-1:0] w_q [NK][9];
    logic signed [DW-1:0] b_q [NK];

    // Stage 1: products, bias, relu flag
    logic                 v1_q;
    logic                 relu1_q;
    logic signed [PW-1:0] prod_d  [NK][9];
    logic signed [PW-1:0] prod_q  [NK][9];
    logic signed [DW-1:0] bias1_q [NK];

    // Stage 2: two partial sums per kernel
    logic                 v2_q;
    logic                 relu2_q;
    logic signed [AW-1:0] psa_d [NK];
    logic signed [AW-1:0] psb_d [NK];
    logic signed [AW-1:0] psa_q [NK];
    logic signed [AW-1:0] psb_q [NK];

    // Stage 3: final result
    logic                 v3_q;
    logic [NK*DW-1:0]     res_d;
    logic [NK*DW-1:0]     res_q;

    logic adv1, adv2, adv3, accept;

    function automatic logic signed [PW-1:0] sext_p(input logic [DW-1:0] v);
        return {{(PW-DW){v[DW-1]}}, v};
    endfunction

    function automatic logic signed [AW-1:0] sext_a(input logic [PW-1:0] v);
        return {{(AW-PW){v[PW-1]}}, v};
    endfunction

    function automatic logic signed [AW-1:0] sext_b(input logic [DW-1:0] v);
        return {{(AW-DW){v[DW-1]}}, v};
    endfunction

    // A stage may load when it is empty or its contents move on this edge.
    assign adv3    = !v3_q || o_ready;
    assign adv2    = !v2_q || adv3;
    assign adv1    = !v1_q || adv2;
    assign i_ready = !w_we && adv1;
    assign accept  = i_valid && i_ready;
    assign o_valid = v3_q;
    assign o_data  = res_q;

    // Coefficient write port; out-of-range kernel or tap codes 10-15 fall through unmatched.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NK; k++) begin
                for (int t = 0; t < 9; t++) begin
                    w_q[k][t] <= W_INIT[(k*9+t)*DW +: DW];
                end
                b_q[k] <= B_INIT[k*DW +: DW];
            end
        end else if (w_we) begin
            for (int k = 0; k < NK; k++) begin
                if ((NK == 1) || (w_kidx == KW'(k))) begin
                    if (w_tap == 4'd9) begin
                        b_q[k] <= w_data;
                    end
                    for (int t = 0; t < 9; t++) begin
                        if (w_tap == 4'(t)) begin
                            w_q[k][t] <= w_data;
                        end
                    end
                end
            end
        end
    end

    // Full-precision products of the incoming window with current weights.
    always_comb begin
        for (int k = 0; k < NK; k++) begin
            for (int t = 0; t < 9; t++) begin
                prod_d[k][t] = sext_p(i_data[t*DW +: DW]) * sext_p(w_q[k][t]);
            end
        end
    end

    // Partial sums: taps 0-4 plus aligned bias, and taps 5-8.
    always_comb begin
        for (int k = 0; k < NK; k++) begin
            psa_d[k] = sext_b(bias1_q[k]) <<< FRAC;
            psb_d[k] = '0;
            for (int t = 0; t < 5; t++) begin
                psa_d[k] = psa_d[k] + sext_a(prod_q[k][t]);
            end
            for (int t = 5; t < 9; t++) begin
                psb_d[k] = psb_d[k] + sext_a(prod_q[k][t]);
            end
        end
    end

    // Round half up at full width, saturate to DW bits, then optional ReLU.
    always_comb begin
        logic signed [AW-1:0] total;
        logic signed [AW-1:0] rnd;
        logic [DW-1:0]        lane;
        res_d = '0;
        total = '0;
        rnd   = '0;
        lane  = '0;
        for (int k = 0; k < NK; k++) begin
            total = psa_q[k] + psb_q[k];
            rnd   = (total >>> FRAC) + $signed({{(AW-1){1'b0}}, total[FRAC-1]});
            if (rnd > SAT_MAX) begin
                lane = OUT_MAX;
            end else if (rnd < SAT_MIN) begin
                lane = OUT_MIN;
            end else begin
                lane = rnd[DW-1:0];
            end
            if (relu2_q && lane[DW-1]) begin
                lane = '0;
            end
            res_d[k*DW +: DW] = lane;
        end
    end

    // Pipeline registers; reset drops every in-flight window at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            relu1_q <= 1'b0;
            relu2_q <= 1'b0;
            res_q   <= '0;
            for (int k = 0; k < NK; k++) begin
                bias1_q[k] <= '0;
                psa_q[k]   <= '0;
                psb_q[k]   <= '0;
                for (int t = 0; t < 9; t++) begin
                    prod_q[k][t] <= '0;
                end
            end
        end else begin
            if (adv1) begin
                v1_q <= accept;
                if (accept) begin
                    relu1_q <= relu_en;
                    for (int k = 0; k < NK; k++) begin
                        bias1_q[k] <= b_q[k];
                        for (int t = 0; t < 9; t++) begin
                            prod_q[k][t] <= prod_d[k][t];
                        end
                    end
                end
            end
            if (adv2) begin
                v2_q <= v1_q;
                if (v1_q) begin
                    relu2_q <= relu1_q;
                    for (int k = 0; k < NK; k++) begin
                        psa_q[k] <= psa_d[k];
                        psb_q[k] <= psb_d[k];
                    end
                end
            end
            if (adv3) begin
                v3_q <= v2_q;
                if (v2_q) begin
                    res_q <= res_d;
                end
            end
        end
    end

endmodule

// File: doc/conv_engine.md
CONV_ENGINE -- requirements
Module: conv_engine

Interface
REQ-001 SHALL have parameter DW, default 20, signed fixed-point data/weight/bias width.
REQ-002 SHALL have parameter FRAC, default 16, fraction bits of data, weights and bias (Q(DW-FRAC).FRAC).
REQ-003 SHALL have parameter NK, default 2, number of 3x3 kernels evaluated in parallel on the same window.
REQ-004 SHALL have parameter W_INIT, default all-zero, width NK*9*DW, reset weight values; kernel k tap t at [(k*9+t)*DW +: DW].
REQ-005 SHALL have parameter B_INIT, default all-zero, width NK*DW, reset bias values; kernel k at [k*DW +: DW].
REQ-006 SHALL have ports: clk  in  1  rising-edge clock.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 i_valid  in  1  window valid.
REQ-009 i_ready  out  1  window accepted when i_valid && i_ready.
REQ-010 i_data  in  9*DW  3x3 window; tap t at [t*DW +: DW].
REQ-011 relu_en  in  1  ReLU enable, sampled with each accepted window.
REQ-012 w_we  in  1  coefficient write strobe.
REQ-013 w_kidx  in  max(1,$clog2(NK))  target kernel.
REQ-014 w_tap  in  4  0-8 = weight tap, 9 = bias, 10-15 = write ignored.
REQ-015 w_data  in  DW  coefficient value.
REQ-016 o_valid  out  1  result valid.
REQ-017 o_ready  in  1  downstream accepts when o_valid && o_ready.
REQ-018 o_data  out  NK*DW  results; kernel k at [k*DW +: DW].

Function
REQ-019 SHALL be a 3-stage elastic pipeline: S1 registers 9*NK products (2*DW each), the selected bias and relu_en; S2 registers two partial sums per kernel; S3 registers the rounded result on o_data.
REQ-020 Each stage SHALL advance when its successor is empty or advancing; S3 advances on o_ready or when empty.
REQ-021 i_ready SHALL equal !w_we && (S1 empty || S1 advancing); no window is accepted in a w_we cycle.
REQ-022 Latency SHALL be 3 cycles from acceptance to o_valid with o_ready held high; throughput one window per cycle.
REQ-023 o_data SHALL hold stable while o_valid && !o_ready; no result lost, duplicated or reordered.
REQ-024 Coefficient writes with w_kidx >= NK or w_tap > 9 SHALL be ignored.
REQ-025 A window SHALL use the coefficients present at its acceptance cycle; a write affects only windows accepted on later cycles.
REQ-026 Products SHALL be signed DW x DW; accumulation SHALL be signed, 2*DW+4 bits, bias sign-extended and shifted left FRAC.
REQ-027 Rounding SHALL be total[FRAC +: ...] + total[FRAC-1] (round half up), computed at full accumulator width.
REQ-028 The rounded value SHALL saturate to [-2^(DW-1), 2^(DW-1)-1], never wrap.
REQ-029 If the window's relu_en is 1, negative saturated results SHALL become 0.
REQ-030 When NK = 1, w_kidx SHALL be 1 bit and bit value ignored.

Reset
REQ-031 While reset is low: S1-S3 valids = 0, o_valid = 0, o_data = 0, weights = W_INIT, biases = B_INIT.
REQ-032 Reset asserted mid-operation SHALL discard all in-flight windows immediately; no partial result appears after release.
REQ-033 i_ready SHALL be 1 in the first cycle after reset release (w_we low).

Verification (DW=20, FRAC=16, NK=2, 1.0 = 20'h10000)
REQ-034 Reset with valid stream running -> o_valid=0, o_data=0 asynchronously; after release, first output only from a newly accepted window.
REQ-035 Write k0 tap0=20'h10000, bias=20'h08000; window tap0=20'h20000, others 0, relu_en=0 -> 3 cycles later o_data[19:0]=20'h28000.
REQ-036 k0 tap0=20'hF0000 (-1.0), bias 0, tap0 input 20'h30000 -> relu_en=0: 20'hD0000; relu_en=1: 20'h00000.
REQ-037 All k1 weights 20'h7FFFF, inputs 20'h7FFFF -> 20'h7FFFF; inputs 20'h80001 with relu_en=0 -> 20'h80000.
REQ-038 k0 tap0=20'h00001, input 20'h08000 -> result 20'h00001 (round half up); input 20'h07FFF -> 20'h00000.
REQ-039 Stream 8 distinct windows, o_ready low 4 cycles mid-stream, w_we pulsed once -> 8 ordered results, o_data stable during stall, i_ready low when full and during w_we, new coefficient applies only to windows accepted after the write.
